// File: rtl/i2c_pkg.sv
// Shared types and constants for the arbitrated I2C write master.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    START,
    BYTE,
    ACK,
    STOP,
    DONE
  } arb_state_t;

  localparam int unsigned FRAME_BYTES = 3;
  localparam int unsigned BYTE_BITS   = 8;

  // Byte idx of a frame: {addr,W}, data[11:4], {data[3:0],4'b0}.
  function automatic logic [7:0] frame_byte(input logic [6:0]  addr,
                                            input logic [11:0] data,
                                            input logic [1:0]  idx);
    case (idx)
      2'd0:    frame_byte = {addr, 1'b0};
      2'd1:    frame_byte = data[11:4];
      default: frame_byte = {data[3:0], 4'b0000};
    endcase
  endfunction

endpackage

// File: rtl/i2c_tick_gen.sv
// Free-running divider producing a one-cycle tick every DIV clocks;
// synchronous clear restarts the period so a frame begins on a full tick.
module i2c_tick_gen #(
  parameter int unsigned DIV = 100
) (
  input  logic clk,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(DIV - 1));

  // Period counter
  always_ff @(posedge clk) begin
    if (clr || tick) cnt <= '0;
    else             cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/i2c_write_arb.sv
// Round-robin arbiter in front of a 3-byte I2C write master.
// Optional macro I2C_WRITE_ARB_RETRY_EN: a NACKed frame is resent once.
module i2c_write_arb
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_DIV = 400,
  parameter int unsigned NUM_REQ = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*7-1:0]  req_addr,
  input  logic [NUM_REQ*12-1:0] req_data,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [NUM_REQ-1:0]    done,
  output logic                  err,
  output logic                  scl,
  inout  wire                   sda
);

  localparam int unsigned IDXW = (NUM_REQ > 2) ? 2 : 1;

  arb_state_t      state, state_nx;
  logic [IDXW-1:0] rr_ptr, owner, pick;
  logic [6:0]      addr_r;
  logic [11:0]     data_r;
  logic [1:0]      qtr;
  logic [2:0]      bit_idx;
  logic [1:0]      byte_idx;
  logic            nack_r;
  logic            sda_meta, sda_sync;
  logic            sda_low;
  logic            tick, tick_clr;
  logic            retry_go;
  logic [7:0]      cur_byte;

  assign sda      = sda_low ? 1'b0 : 1'bz;
  assign tick_clr = rst || (state == ARB);
  assign cur_byte = frame_byte(addr_r, data_r, byte_idx);

  i2c_tick_gen #(.DIV(CLK_DIV / 4)) u_tick (
    .clk  (clk),
    .clr  (tick_clr),
    .tick (tick)
  );

`ifdef I2C_WRITE_ARB_RETRY_EN
  logic retried;

  assign retry_go = nack_r && !retried;

  // One retry per grant: armed at ARB, consumed at the end of the first STOP
  always_ff @(posedge clk) begin
    if (rst || state == ARB)                                retried <= 1'b0;
    else if (state == STOP && tick && qtr == 2'd1 && retry_go) retried <= 1'b1;
  end
`else
  assign retry_go = 1'b0;
`endif

  // Round-robin search starting at rr_ptr
  always_comb begin
    logic found;
    found = 1'b0;
    pick  = rr_ptr;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && req[(32'(rr_ptr) + i) % NUM_REQ]) begin
        found = 1'b1;
        pick  = IDXW'((32'(rr_ptr) + i) % NUM_REQ);
      end
    end
  end

  // ACK input synchronizer
  always_ff @(posedge clk) begin
    if (rst) begin
      sda_meta <= 1'b1;
      sda_sync <= 1'b1;
    end else begin
      sda_meta <= sda;
      sda_sync <= sda_meta;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic; bus states advance only on ticks
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (|req) state_nx = ARB;
      ARB:   state_nx = START;
      START: if (tick && qtr == 2'd1) state_nx = BYTE;
      BYTE:  if (tick && qtr == 2'd3 && bit_idx == 3'd0) state_nx = ACK;
      ACK:   if (tick && qtr == 2'd3)
               state_nx = (nack_r || byte_idx == 2'(FRAME_BYTES - 1)) ? STOP : BYTE;
      STOP:  if (tick && qtr == 2'd1) state_nx = retry_go ? START : DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Frame datapath: owner, latched payload, bit/byte/quarter counters, ACK status
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= '0;
      owner    <= '0;
      addr_r   <= '0;
      data_r   <= '0;
      qtr      <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      nack_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (|req) owner <= pick;
        ARB: begin
          addr_r   <= req_addr[owner*7 +: 7];
          data_r   <= req_data[owner*12 +: 12];
          rr_ptr   <= (32'(owner) == NUM_REQ - 1) ? '0 : owner + 1'b1;
          qtr      <= '0;
          bit_idx  <= 3'(BYTE_BITS - 1);
          byte_idx <= '0;
          nack_r   <= 1'b0;
        end
        START: if (tick) begin
          qtr <= (qtr == 2'd1) ? 2'd0 : qtr + 2'd1;
        end
        BYTE: if (tick) begin
          qtr <= qtr + 2'd1;
          if (qtr == 2'd3) bit_idx <= bit_idx - 3'd1;
        end
        ACK: if (tick) begin
          qtr <= qtr + 2'd1;
          if (qtr == 2'd2) nack_r   <= sda_sync;
          if (qtr == 2'd3) byte_idx <= byte_idx + 2'd1;
        end
        STOP: if (tick) begin
          qtr <= (qtr == 2'd1) ? 2'd0 : qtr + 2'd1;
          if (qtr == 2'd1 && retry_go) begin
            nack_r   <= 1'b0;
            byte_idx <= '0;
            bit_idx  <= 3'(BYTE_BITS - 1);
          end
        end
        default: ;
      endcase
    end
  end

  // Bus and handshake outputs decoded from state and quarter
  always_comb begin
    scl     = 1'b1;
    sda_low = 1'b0;
    gnt     = '0;
    done    = '0;
    err     = 1'b0;
    if (state != IDLE) gnt[owner] = 1'b1;
    case (state)
      START: sda_low = (qtr == 2'd1);
      BYTE: begin
        scl     = (qtr == 2'd1) || (qtr == 2'd2);
        sda_low = !cur_byte[bit_idx];
      end
      ACK:   scl = (qtr == 2'd1) || (qtr == 2'd2);
      STOP:  sda_low = (qtr == 2'd0);
      DONE: begin
        done[owner] = 1'b1;
        err         = nack_r;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_i2c_write_arb.sv
// Self-checking bench for i2c_write_arb: bus-level slave model, directed
// scenarios and randomized single transactions against a frame-level model.
module tb_i2c_write_arb;

  localparam int unsigned CLK_DIV = 8;
  localparam int unsigned DIV     = CLK_DIV / 4;
  localparam logic [6:0]  SLAVE_ADDR = 7'd52;
`ifdef I2C_WRITE_ARB_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = '0;
  logic [13:0] req_addr = '0;
  logic [23:0] req_data = '0;
  logic [1:0]  gnt, done;
  logic        err, scl;
  wire         sda;
  logic        slave_low = 1'b0;
  logic        sda_v;

  pullup (sda);
  assign sda   = slave_low ? 1'b0 : 1'bz;
  assign sda_v = (sda === 1'b0) ? 1'b0 : 1'b1;

  i2c_write_arb #(.CLK_DIV(CLK_DIV), .NUM_REQ(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_addr (req_addr),
    .req_data (req_data),
    .gnt      (gnt),
    .done     (done),
    .err      (err),
    .scl      (scl),
    .sda      (sda)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int checks = 0;
  int failures = 0;

  // Slave model state
  logic [7:0] rx_q[$];
  int   starts = 0, stops = 0;
  int   nack_b2_left = 0;
  int   bitn = 0, byte_i = 0;
  bit   in_frame = 0;
  logic [7:0] shreg = '0;
  logic pscl = 1'b1, psda = 1'b1;

  // Slave at address SLAVE_ADDR: ACKs its address, optionally NACKs byte 2
  always @(negedge clk) begin
    if (rst) begin
      bitn = 0; in_frame = 0; slave_low = 1'b0;
    end else if (pscl && scl && psda && !sda_v) begin
      starts++; bitn = 0; byte_i = 0; in_frame = 1; slave_low = 1'b0;
    end else if (pscl && scl && !psda && sda_v) begin
      stops++; in_frame = 0; slave_low = 1'b0;
    end else if (!pscl && scl && in_frame) begin
      if (bitn < 8) begin shreg = {shreg[6:0], sda_v}; bitn++; end
      else bitn = 9;
    end else if (pscl && !scl && in_frame) begin
      if (bitn == 8) begin
        rx_q.push_back(shreg);
        if (byte_i == 0) slave_low = (shreg[7:1] == SLAVE_ADDR);
        else if (byte_i == 2 && nack_b2_left > 0) begin
          nack_b2_left--; slave_low = 1'b0;
        end else slave_low = 1'b1;
        byte_i++;
      end else if (bitn == 9) begin
        slave_low = 1'b0; bitn = 0;
      end
    end
    pscl = scl;
    psda = sda_v;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_gnt(output logic [1:0] g, output int c);
    g = '0; c = cyc;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (gnt != 0) break;
    end
    g = gnt; c = cyc;
    check("gnt_seen", 64'(gnt != 0), 64'd1);
  endtask

  task automatic wait_done(input int idx, input int drop_after,
                           output logic [1:0] dn, output logic e, output int c);
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      if (k == drop_after) req[idx] = 1'b0;
      if (done != 0) break;
    end
    dn = done; e = err; c = cyc;
    check("done_seen", 64'(done != 0), 64'd1);
  endtask

  function automatic logic [63:0] pack_rx();
    logic [63:0] w;
    w = '0;
    foreach (rx_q[k]) w = {w[55:0], rx_q[k]};
    return w;
  endfunction

  // Single-requester transaction checked against a frame-level model
  task automatic run_txn(input int idx, input logic [6:0] a, input logic [11:0] d,
                         input int nb2, input int drop_tick, input string tag);
    logic [63:0] exp_bytes;
    int   exp_n, exp_att, exp_ticks, left, gc, dc, s0, p0;
    bit   exp_err, nk;
    logic [1:0] g, dn;
    logic e;
    left = nb2; exp_bytes = '0; exp_n = 0; exp_att = 0; exp_ticks = 0; exp_err = 0;
    for (int att = 0; att < 2; att++) begin
      exp_att++;
      exp_bytes = {exp_bytes[55:0], a, 1'b0}; exp_n++;
      if (a != SLAVE_ADDR) begin
        nk = 1; exp_ticks += 40;
      end else begin
        exp_bytes = {exp_bytes[47:0], d[11:4], d[3:0], 4'h0}; exp_n += 2;
        nk = (left > 0);
        if (left > 0) left--;
        exp_ticks += 112;
      end
      exp_err = nk;
      if (!nk || !RETRY) break;
    end

    req_addr[idx*7 +: 7]   = a;
    req_data[idx*12 +: 12] = d;
    nack_b2_left = nb2;
    rx_q.delete();
    s0 = starts; p0 = stops;
    req[idx] = 1'b1;
    wait_gnt(g, gc);
    check({tag, "_gnt"}, 64'(g), 64'(2'b01 << idx));
    wait_done(idx, (drop_tick < 0) ? -1 : drop_tick * DIV, dn, e, dc);
    req[idx] = 1'b0;
    check({tag, "_done"}, 64'(dn), 64'(2'b01 << idx));
    check({tag, "_err"}, 64'(e), 64'(exp_err));
    check({tag, "_len"}, 64'(dc - gc), 64'(1 + DIV * exp_ticks));
    @(negedge clk);
    check({tag, "_after_done"}, 64'({gnt, done}), 64'd0);
    check({tag, "_nbytes"}, 64'(rx_q.size()), 64'(exp_n));
    check({tag, "_bytes"}, pack_rx(), exp_bytes);
    check({tag, "_frames"}, 64'(starts - s0), 64'(exp_att));
    check({tag, "_stops"}, 64'(stops - p0), 64'(exp_att));
    repeat (4) @(negedge clk);
  endtask

  // Both requesters together; expects 0 then 1 with a two-cycle gap
  task automatic run_pair(input string tag);
    logic [11:0] d0, d1;
    logic [1:0]  g, dn;
    logic        e;
    int          gc, dc;
    d0 = 12'($urandom); d1 = 12'($urandom);
    req_addr = {SLAVE_ADDR, SLAVE_ADDR};
    req_data = {d1, d0};
    nack_b2_left = 0;
    rx_q.delete();
    req = 2'b11;
    wait_gnt(g, gc);
    check({tag, "_gnt0"}, 64'(g), 64'(2'b01));
    wait_done(0, -1, dn, e, dc);
    req[0] = 1'b0;
    check({tag, "_done0"}, 64'(dn), 64'(2'b01));
    wait_gnt(g, gc);
    check({tag, "_gnt1"}, 64'(g), 64'(2'b10));
    check({tag, "_gap"}, 64'(gc - dc), 64'd2);
    wait_done(1, -1, dn, e, dc);
    req[1] = 1'b0;
    check({tag, "_done1"}, 64'(dn), 64'(2'b10));
    check({tag, "_err1"}, 64'(e), 64'd0);
    check({tag, "_bytes"}, pack_rx(),
          {16'h0, SLAVE_ADDR, 1'b0, d0, 4'h0, SLAVE_ADDR, 1'b0, d1, 4'h0});
    repeat (4) @(negedge clk);
  endtask

  initial begin
    logic [1:0]  g;
    logic        dseen;
    logic [6:0]  ra;
    int          gc;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_scl", 64'(scl), 64'd1);
    check("rst_sda", 64'(sda_v), 64'd1);
    check("rst_gnt", 64'(gnt), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Simultaneous requests after reset
    run_pair("rr_pair");

    // Basic ACKed write: bytes 68h A5h C0h
    run_txn(0, 7'd52, 12'hA5C, 0, -1, "basic");
    check("basic_b0", 64'(rx_q[0]), 64'h68);

    // No slave at address 53
    run_txn(0, 7'd53, 12'h123, 0, -1, "nack_addr");

    // NACK on the last byte of the first attempt only
    run_txn(1, 7'd52, 12'h3C7, 1, -1, "nack_b2");

    // Requester withdraws at tick 20
    run_txn(0, 7'd52, 12'h5E1, 0, 20, "drop");

    // Reset in the middle of a frame
    req_addr[6:0]  = SLAVE_ADDR;
    req_data[11:0] = 12'($urandom);
    nack_b2_left = 0;
    req = 2'b01;
    wait_gnt(g, gc);
    repeat (1 + 50 * DIV) @(posedge clk);
    #1 rst = 1'b1;
    req = 2'b00;
    @(posedge clk);
    #1;
    check("midrst_scl", 64'(scl), 64'd1);
    check("midrst_sda", 64'(sda_v), 64'd1);
    check("midrst_gnt", 64'(gnt), 64'd0);
    rst = 1'b0;
    dseen = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (done != 0) dseen = 1'b1;
    end
    check("midrst_no_done", 64'(dseen), 64'd0);

    // Pointer must be back at 0 after reset
    run_pair("rr_after_rst");

    // Randomized single transactions
    for (int n = 0; n < 8; n++) begin
      ra = SLAVE_ADDR;
      if ($urandom_range(0, 3) == 0) begin
        ra = 7'($urandom_range(0, 127));
        if (ra == SLAVE_ADDR) ra = SLAVE_ADDR + 7'd1;
      end
      run_txn(int'($urandom_range(0, 1)), ra, 12'($urandom),
              ($urandom_range(0, 3) == 0) ? 1 : 0, -1, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
